// File: rtl/i2c_master_pkg.sv
// i2c_master_pkg: shared state/symbol encodings and bus constants for the I2C master.
package i2c_master_pkg;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR_W,
    ST_INDEX,
    ST_WDATA,
    ST_RESTART,
    ST_ADDR_R,
    ST_RDATA,
    ST_STOP
  } state_e;
  typedef enum logic [1:0] {
    SYM_START,
    SYM_RESTART,
    SYM_BIT,
    SYM_STOP
  } sym_e;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h55;
endpackage

// File: rtl/i2c_master_sym.sv
// i2c_master_sym: clock divider and quarter-phase generator for one bus symbol.
module i2c_master_sym
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sym_go,
  input  sym_e sym_type,
  input  logic tx_bit,
  input  logic sda_i,
  output logic sym_done,
  output logic rx_bit,
  output logic scl_oe,
  output logic sda_oe
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] ph_q, ph_d;
  logic rx_q, rx_d, tick;
  // Symbols run back to back while sym_go is held; phase restarts at Q0 whenever it drops.
  always_comb begin
    tick = div_q == DW'(CLK_DIV - 1);
    div_d = !sym_go || tick ? '0 : div_q + DW'(1);
    ph_d = !sym_go ? 2'd0 : ph_q + 2'(tick);
    rx_d = sym_go && tick && ph_q == 2'd1 ? sda_i : rx_q;
    sym_done = sym_go && tick && ph_q == 2'd3;
    rx_bit = rx_q;
    scl_oe = sym_go && (sym_type == SYM_START ? ph_q == 2'd3 :
                        sym_type == SYM_STOP  ? ph_q == 2'd0 :
                        ph_q == 2'd0 || ph_q == 2'd3);
    sda_oe = sym_go && (sym_type == SYM_BIT  ? !tx_bit :
                        sym_type == SYM_STOP ? !ph_q[1] : ph_q[1]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      ph_q <= 2'd0;
      rx_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ph_q <= ph_d;
      rx_q <= rx_d;
    end
  end
endmodule

// File: rtl/i2c_master.sv
// i2c_master: one register write or read per command to an I2C register slave.
// Drives SCL/SDA as open-drain pull-down enables; SCL is never sampled.
module i2c_master
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_idx,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);
  state_e state_q, state_d;
  sym_e sym_type;
  logic [3:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, idx_q, idx_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [6:0] dev_q, dev_d;
  logic rw_q, rw_d, err_q, err_d, done_q, done_d;
  logic sym_done, rx_bit, tx_bit, last;

  i2c_master_sym #(.CLK_DIV(CLK_DIV)) u_sym (
    .clk(clk),
    .rst_n(rst_n),
    .sym_go(busy),
    .sym_type(sym_type),
    .tx_bit(tx_bit),
    .sda_i(sda_i),
    .sym_done(sym_done),
    .rx_bit(rx_bit),
    .scl_oe(scl_oe),
    .sda_oe(sda_oe)
  );

  assign busy = state_q != ST_IDLE;
  assign done = done_q;
  assign ack_err = err_q;
  assign rdata = rdata_q;

  // sh_q shifts out the byte being sent and shifts in the sampled line, so it doubles as the read register.
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    dev_d = dev_q;
    rw_d = rw_q;
    err_d = err_q;
    done_d = 1'b0;
    last = bit_q == 4'd8;
    tx_bit = state_q == ST_RDATA || last ? 1'b1 : sh_q[7];
    sym_type = state_q == ST_START   ? SYM_START :
               state_q == ST_RESTART ? SYM_RESTART :
               state_q == ST_STOP    ? SYM_STOP : SYM_BIT;
    if (state_q == ST_IDLE) begin
      if (cmd_valid) begin
        state_d = ST_START;
        rw_d = cmd_rw;
        dev_d = cmd_dev_addr;
        idx_d = cmd_idx;
        wdata_d = cmd_wdata;
        err_d = 1'b0;
      end
    end else if (sym_done) begin
      if (state_q == ST_START || state_q == ST_RESTART) begin
        state_d = state_q == ST_START ? ST_ADDR_W : ST_ADDR_R;
        sh_d = {dev_q, state_q == ST_START ? RW_WRITE : RW_READ};
        bit_d = 4'd0;
      end else if (state_q == ST_STOP) begin
        state_d = ST_IDLE;
        done_d = 1'b1;
      end else if (!last) begin
        sh_d = {sh_q[6:0], rx_bit};
        bit_d = bit_q + 4'd1;
        if (state_q == ST_RDATA && bit_q == 4'd7) rdata_d = {sh_q[6:0], rx_bit};
      end else begin
        bit_d = 4'd0;
        if (rx_bit && state_q != ST_RDATA) begin
          err_d = 1'b1;
          state_d = ST_STOP;
        end else begin
          state_d = state_q == ST_ADDR_W ? ST_INDEX :
                    state_q == ST_INDEX  ? (rw_q ? ST_RESTART : ST_WDATA) :
                    state_q == ST_ADDR_R ? ST_RDATA : ST_STOP;
          sh_d = state_q == ST_ADDR_W ? idx_q : wdata_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q <= 4'd0;
      sh_q <= 8'h00;
      idx_q <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      dev_q <= 7'h00;
      rw_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dev_q <= dev_d;
      rw_q <= rw_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-register I2C master; the initiator side for the team's I2C register slave (device 0x55, 8-bit index pointer, 8-bit registers).
- Performs exactly one register write (S, addr+W, index, data, P) or one register read (S, addr+W, index, Sr, addr+R, data with master NACK, P) per command.
- Drives SCL/SDA as open-drain enables. Lets on-chip logic or the tile top program and read back the slave's address/instruction registers.

Parameters:
- CLK_DIV, 4, clk cycles per quarter-bit phase (≥1); one bus symbol = 4*CLK_DIV clk cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  one-cycle command request; accepted only when busy=0
- cmd_rw  in  1  0=register write, 1=register read
- cmd_dev_addr  in  7  7-bit slave address
- cmd_idx  in  8  register index
- cmd_wdata  in  8  write data (ignored for read)
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- ack_err  out  1  slave NACK seen in last transaction; valid with done, held until next accept
- rdata  out  8  read data; updated only on successful read, held otherwise
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- sda_i  in  1  sampled SDA pad level

Behaviour:
- Reset (rst_n=0 at posedge clk): scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rdata=0x00, FSM=IDLE, divider=0. Mid-transaction reset releases both lines on the next edge; no STOP is generated.
- Accept: cmd_valid & !busy latches all cmd_* fields; busy=1 on the next cycle; ack_err cleared. cmd_valid while busy is ignored, with no effect on the transfer.
- Divider: a quarter tick every CLK_DIV cycles; the phase counter Q0..Q3 advances on each tick. All line changes occur at quarter boundaries.
- Symbols (oe values listed; released = 0):
  - START: Q0,Q1 SCL/SDA released; Q2 SDA low; Q3 SCL low.
  - RESTART: Q0 SCL low, SDA released; Q1 SCL released; Q2 SDA low; Q3 SCL low.
  - BIT: Q0 SCL low, SDA=bit; Q1,Q2 SCL released; sda_i sampled at Q1→Q2 boundary; Q3 SCL low.
  - STOP: Q0 SCL low, SDA low; Q1 SCL released; Q2 SDA released; Q3 idle.
- Bytes are sent MSB first. The ACK slot is a BIT with SDA released; sda_i=0 means ACK.
- No clock stretching and no arbitration: SCL is never sampled.
- FSM: IDLE → START → ADDR_W(8b+ack) → INDEX(8b+ack).
  - Write path: → WDATA(8b+ack) → STOP → IDLE.
  - Read path: → RESTART → ADDR_R(8b+ack) → RDATA(8b sampled, master NACK: SDA released) → STOP → IDLE.
- Address byte = {cmd_dev_addr, R/W}, e.g. dev 0x55 gives 0xAA (write) / 0xAB (read).
- NACK at any ack slot: ack_err=1, skip the remaining bytes, go to STOP, then done. rdata is unchanged.
- Length: write = 29 symbols = 116*CLK_DIV cycles from accept to done; read = 39 symbols = 156*CLK_DIV cycles (±1 cycle registration, fixed and documented in the bench).
- done pulses in the same cycle busy falls. A new cmd_valid is accepted in the cycle after done.
- rdata is loaded on the last data bit of RDATA when all acks were good.
- Divider and bit counters never wrap mid-symbol. CLK_DIV=1 is legal, giving a 4-cycle symbol.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, START, ADDR_W, INDEX, WDATA, RESTART, ADDR_R, RDATA, STOP).
  - Symbol-type encoding (SYM_START, SYM_RESTART, SYM_BIT, SYM_STOP).
  - R/W bit constants.
  - Default slave address 0x55 for benches.
- One sub-module, i2c_master_sym: divider plus the quarter-phase symbol generator.
  - Inputs: sym_go, sym_type, tx_bit.
  - Outputs: sym_done, rx_bit, scl_oe, sda_oe.
- The top holds the byte/transaction FSM, the bit counter and the shift registers.

Test Plan:
- Write dev 0x55 idx 0x03 data 0x57, slave model ACKs all → bus decoder sees S,0xAA,A,0x03,A,0x57,A,P; done after 116*CLK_DIV cycles; ack_err=0; model reg3=0x57.
- Read dev 0x55 idx 0x03 (model reg3=0x57) → S,0xAA,0x03,Sr,0xAB, slave drives 0x57, master NACK, P; rdata=0x57; ack_err=0.
- Write dev 0x20, no slave responds → NACK on first ack; STOP right after; done with ack_err=1; rdata unchanged; 11 symbols total.
- cmd_valid pulsed mid-transfer with different fields → ignored; bus bytes match the first command only; single done.
- rst_n low during INDEX byte → next cycle scl_oe=0, sda_oe=0, busy=0; a new write then completes correctly.
- CLK_DIV=1, back-to-back write then read with cmd_valid in the cycle after done → both accepted, correct bytes, no idle gap violation (SCL/SDA high ≥4 cycles between P and S).
